// File: rtl/pmem_burst_adaptor_if.sv
// Signal bundle between the L1 cache memory port, the burst adaptor and the physical memory bus.
// The adaptor takes the slave view; the environment (cache plus memory model) takes the master view.
interface pmem_burst_adaptor_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [31:0]        pmem_addr;
  logic [s_line-1:0]  pmem_wdata;
  logic               pmem_read;
  logic               pmem_write;
  logic [s_line-1:0]  pmem_rdata;
  logic               pmem_resp;

  logic [31:0]        bus_addr;
  logic [s_burst-1:0] bus_wdata;
  logic [s_burst-1:0] bus_rdata;
  logic               bus_read;
  logic               bus_write;
  logic               bus_resp;

  modport slave (
    input  pmem_addr, pmem_wdata, pmem_read, pmem_write, bus_rdata, bus_resp,
    output pmem_rdata, pmem_resp, bus_addr, bus_wdata, bus_read, bus_write
  );

  modport master (
    output pmem_addr, pmem_wdata, pmem_read, pmem_write, bus_rdata, bus_resp,
    input  pmem_rdata, pmem_resp, bus_addr, bus_wdata, bus_read, bus_write
  );
endinterface

// File: rtl/pmem_burst_adaptor.sv
// Converts one full-line cache read/write into a num_beats burst on the memory bus,
// reassembling or serializing the line, then returns a one-cycle pmem_resp.
//
// state    | meaning
// IDLE     | waiting for pmem_read / pmem_write (read wins)
// RD_BURST | bus_read high, collecting beats on bus_resp
// RD_DONE  | pmem_resp pulse, pmem_rdata holds the full line
// WR_BURST | bus_write high, presenting beats on bus_resp
// WR_DONE  | pmem_resp pulse
module pmem_burst_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input logic               clk,
  input logic               rst,
  pmem_burst_adaptor_if.slave io
);
  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = $clog2(num_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_e;

  state_e                            state_q, state_d;
  logic [cnt_w-1:0]                  cnt_q, cnt_d;
  logic [31:0]                       addr_q, addr_d;
  logic [num_beats-1:0][s_burst-1:0] wr_line_q, wr_line_d;
  logic [num_beats-1:0][s_burst-1:0] rd_buf_q, rd_buf_d;
  logic [num_beats-1:0][s_burst-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_line_q <= '0;
      rd_buf_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_line_q <= wr_line_d;
      rd_buf_q  <= rd_buf_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_line_d = wr_line_q;
    rd_buf_d  = rd_buf_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (io.pmem_read) begin
          addr_d  = io.pmem_addr & 32'hFFFF_FFE0;
          state_d = RD_BURST;
        end else if (io.pmem_write) begin
          addr_d    = io.pmem_addr & 32'hFFFF_FFE0;
          wr_line_d = io.pmem_wdata;
          state_d   = WR_BURST;
        end
      end
      RD_BURST: begin
        if (io.bus_resp) begin
          rd_buf_d[cnt_q] = io.bus_rdata;
          cnt_d           = cnt_q + cnt_w'(1);
          // Publish only complete lines so pmem_rdata never shows a partial burst.
          if (cnt_q == last_beat) begin
            rdata_d = rd_buf_d;
            state_d = RD_DONE;
          end
        end
      end
      WR_BURST: begin
        if (io.bus_resp) begin
          cnt_d = cnt_q + cnt_w'(1);
          if (cnt_q == last_beat) state_d = WR_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign io.bus_read   = (state_q == RD_BURST);
  assign io.bus_write  = (state_q == WR_BURST);
  assign io.bus_addr   = addr_q;
  assign io.bus_wdata  = (state_q == WR_BURST) ? wr_line_q[cnt_q] : '0;
  assign io.pmem_resp  = (state_q == RD_DONE) || (state_q == WR_DONE);
  assign io.pmem_rdata = rdata_q;

endmodule
